ula_sequenciador: RTL and testbench

- Controller in front of the 8-bit ALU (ula_8bits) and its sequential multiplier/divider units.
- Accepts one operation at a time from a requester via a valid/ready handshake and registers its operands.
- Drives the ALU inputs, issues a start pulse and waits for done on multi-cycle ops (mult/div), then returns the result with zero/error flags via a second valid/ready handshake.
- Guards against divide-by-zero and a hung sequential unit (timeout).

---
 rtl/ula_pkg.sv | 21 ++
 rtl/ula_temporizador.sv | 24 ++
 rtl/ula_sequenciador.sv | 94 +++++++++
 tb/tb_ula_sequenciador.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// ula_pkg: opcodes, FSM state encoding and constants shared by the ALU sequencer
package ula_pkg;

    localparam logic [2:0] OP_SOMA = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MULT = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_NOT  = 3'd7;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_EXEC   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;

    localparam logic [7:0] ERRO_DIV_RES = 8'hFF;

endpackage

// File: rtl/ula_temporizador.sv
// ula_temporizador: counts cycles spent waiting on the mult/div unit and flags the last allowed one
module ula_temporizador #(
    parameter int TIMEOUT_CICLOS = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [7:0] cnt;

    // Cleared when the unit is started, advances once per waiting cycle
    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            cnt <= 8'd0;
        else if (enable)
            cnt <= cnt + 8'd1;
    end

    assign terminal = enable && (cnt == 8'(TIMEOUT_CICLOS - 1));

endmodule

// File: rtl/ula_sequenciador.sv
// ula_sequenciador: accepts one ALU operation, sequences it (with mult/div start/done) and returns the result
module ula_sequenciador
    import ula_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 32,
    parameter int LARGURA        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [LARGURA-1:0] op_a,
    input  logic [LARGURA-1:0] op_b,
    input  logic [2:0]         op_sel,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [LARGURA-1:0] res_dado,
    output logic               res_zero,
    output logic               res_erro,
    output logic [LARGURA-1:0] ula_a,
    output logic [LARGURA-1:0] ula_b,
    output logic [2:0]         ula_sel,
    input  logic [LARGURA-1:0] ula_resultado,
    output logic               seq_start,
    input  logic               seq_done,
    output logic               ocupado
);

    logic [2:0] state;
    logic       esgotado;

    ula_temporizador #(.TIMEOUT_CICLOS(TIMEOUT_CICLOS)) u_temp (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state == S_START),
        .enable   (state == S_WAIT),
        .terminal (esgotado)
    );

    assign op_ready  = state == S_IDLE;
    assign res_valid = state == S_RESULT;
    assign seq_start = state == S_START;
    assign ocupado   = state != S_IDLE;

    // Operation FSM: registers operands on accept, captures the result and holds it until taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ula_a    <= '0;
            ula_b    <= '0;
            ula_sel  <= '0;
            res_dado <= '0;
            res_zero <= 1'b0;
            res_erro <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (op_valid) begin
                    ula_a   <= op_a;
                    ula_b   <= op_b;
                    ula_sel <= op_sel;
                    if (op_sel == OP_DIV && op_b == '0) begin
                        res_dado <= LARGURA'(ERRO_DIV_RES);
                        res_zero <= 1'b0;
                        res_erro <= 1'b1;
                        state    <= S_RESULT;
                    end else begin
                        state <= (op_sel == OP_MULT || op_sel == OP_DIV) ? S_START : S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_dado <= ula_resultado;
                    res_zero <= ula_resultado == '0;
                    res_erro <= 1'b0;
                    state    <= S_RESULT;
                end
                S_START: state <= S_WAIT;
                S_WAIT: if (seq_done) begin
                    res_dado <= ula_resultado;
                    res_zero <= ula_resultado == '0;
                    res_erro <= 1'b0;
                    state    <= S_RESULT;
                end else if (esgotado) begin
                    res_dado <= '0;
                    res_zero <= 1'b0;
                    res_erro <= 1'b1;
                    state    <= S_RESULT;
                end
                S_RESULT: if (res_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_sequenciador.sv
// tb_ula_sequenciador: table-driven check of the ALU sequencer against a behavioural ALU and mult/div responder
module tb_ula_sequenciador;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sel;
        int         dl;
        logic [7:0] sv;
        logic [7:0] d;
        logic       z;
        logic       e;
        int         lat;
        int         st;
        int         hold;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n, op_valid, op_ready, res_valid, res_ready, res_zero, res_erro;
    logic       seq_start, seq_done, ocupado;
    logic [7:0] op_a, op_b, res_dado, ula_a, ula_b, ula_resultado, seq_val;
    logic [2:0] op_sel, ula_sel;
    int         n_chk = 0;
    int         n_err = 0;
    vec_t       tv[14];

    always #5 clk = ~clk;

    ula_sequenciador #(.TIMEOUT_CICLOS(32), .LARGURA(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_a          (op_a),
        .op_b          (op_b),
        .op_sel        (op_sel),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_dado      (res_dado),
        .res_zero      (res_zero),
        .res_erro      (res_erro),
        .ula_a         (ula_a),
        .ula_b         (ula_b),
        .ula_sel       (ula_sel),
        .ula_resultado (ula_resultado),
        .seq_start     (seq_start),
        .seq_done      (seq_done),
        .ocupado       (ocupado)
    );

    // Behavioural ALU; mult/div output comes from the bench's responder value
    always_comb begin
        ula_resultado = seq_val;
        case (ula_sel)
            3'd0: ula_resultado = ula_a + ula_b;
            3'd1: ula_resultado = ula_a - ula_b;
            3'd4: ula_resultado = ula_a & ula_b;
            3'd5: ula_resultado = ula_a | ula_b;
            3'd6: ula_resultado = ula_a ^ ula_b;
            3'd7: ula_resultado = ~ula_a;
            default: ula_resultado = seq_val;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input string nm);
        int k = -1;
        int lat;
        int st = 0;
        op_a = v.a; op_b = v.b; op_sel = v.sel; op_valid = 1'b1;
        chk({nm, ".op_ready"}, 32'(op_ready), 1);
        @(negedge clk);
        op_valid = 1'b0;
        chk({nm, ".ula_a"}, 32'(ula_a), 32'(v.a));
        chk({nm, ".ula_b"}, 32'(ula_b), 32'(v.b));
        chk({nm, ".ula_sel"}, 32'(ula_sel), 32'(v.sel));
        for (lat = 1; lat < 100 && !res_valid; lat++) begin
            seq_done = 1'b0;
            if (k == 0) begin
                seq_done = 1'b1;
                seq_val  = v.sv;
            end
            if (k >= 0) k--;
            if (seq_start) begin
                st++;
                if (v.dl >= 0) k = v.dl;
            end
            @(negedge clk);
        end
        seq_done = 1'b0;
        chk({nm, ".latency"}, 32'(lat), 32'(v.lat));
        chk({nm, ".starts"}, 32'(st), 32'(v.st));
        chk({nm, ".dado"}, 32'(res_dado), 32'(v.d));
        chk({nm, ".zero"}, 32'(res_zero), 32'(v.z));
        chk({nm, ".erro"}, 32'(res_erro), 32'(v.e));
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            chk({nm, ".hold_valid"}, 32'(res_valid), 1);
            chk({nm, ".hold_dado"}, 32'(res_dado), 32'(v.d));
            chk({nm, ".hold_zero"}, 32'(res_zero), 32'(v.z));
            chk({nm, ".hold_op_ready"}, 32'(op_ready), 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({nm, ".done_valid"}, 32'(res_valid), 0);
        chk({nm, ".done_ocupado"}, 32'(ocupado), 0);
        chk({nm, ".done_op_ready"}, 32'(op_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tv[0]  = '{8'h0F, 8'h01, 3'd0, -1, 8'h00, 8'h10, 1'b0, 1'b0, 2, 0, 0};
        tv[1]  = '{8'h05, 8'h07, 3'd1, -1, 8'h00, 8'hFE, 1'b0, 1'b0, 2, 0, 0};
        tv[2]  = '{8'hF0, 8'h0F, 3'd4, -1, 8'h00, 8'h00, 1'b1, 1'b0, 2, 0, 0};
        tv[3]  = '{8'hA0, 8'h05, 3'd5, -1, 8'h00, 8'hA5, 1'b0, 1'b0, 2, 0, 0};
        tv[4]  = '{8'hAA, 8'hAA, 3'd6, -1, 8'h00, 8'h00, 1'b1, 1'b0, 2, 0, 5};
        tv[5]  = '{8'h3C, 8'h99, 3'd7, -1, 8'h00, 8'hC3, 1'b0, 1'b0, 2, 0, 0};
        tv[6]  = '{8'hFF, 8'h01, 3'd0, -1, 8'h00, 8'h00, 1'b1, 1'b0, 2, 0, 0};
        tv[7]  = '{8'h03, 8'h04, 3'd2,  4, 8'h0C, 8'h0C, 1'b0, 1'b0, 7, 1, 0};
        tv[8]  = '{8'h00, 8'h05, 3'd2,  4, 8'h00, 8'h00, 1'b1, 1'b0, 7, 1, 0};
        tv[9]  = '{8'h20, 8'h00, 3'd3, -1, 8'h00, 8'hFF, 1'b0, 1'b1, 1, 0, 0};
        tv[10] = '{8'h20, 8'h04, 3'd3, -1, 8'h00, 8'h00, 1'b0, 1'b1, 34, 1, 0};
        tv[11] = '{8'h01, 8'h01, 3'd0, -1, 8'h00, 8'h02, 1'b0, 1'b0, 2, 0, 0};
        tv[12] = '{8'h20, 8'h04, 3'd3,  0, 8'h08, 8'h08, 1'b0, 1'b0, 3, 1, 0};
        tv[13] = '{8'h40, 8'h02, 3'd3, 31, 8'h20, 8'h20, 1'b0, 1'b0, 34, 1, 0};

        rst_n = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0; op_sel = '0;
        res_ready = 1'b0; seq_done = 1'b0; seq_val = 8'h5A;
        repeat (2) @(negedge clk);
        chk("rst.res_valid", 32'(res_valid), 0);
        chk("rst.res_dado", 32'(res_dado), 0);
        chk("rst.res_zero", 32'(res_zero), 0);
        chk("rst.res_erro", 32'(res_erro), 0);
        chk("rst.seq_start", 32'(seq_start), 0);
        chk("rst.ula_a", 32'(ula_a), 0);
        chk("rst.ula_sel", 32'(ula_sel), 0);
        chk("rst.ocupado", 32'(ocupado), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.op_ready", 32'(op_ready), 1);

        for (int i = 0; i < 14; i++) run_op(tv[i], $sformatf("vec%0d", i));

        op_a = 8'h03; op_b = 8'h04; op_sel = 3'd2; op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        chk("midrst.wait_ocupado", 32'(ocupado), 1);
        chk("midrst.wait_start", 32'(seq_start), 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst.ocupado", 32'(ocupado), 0);
        chk("midrst.res_valid", 32'(res_valid), 0);
        chk("midrst.res_erro", 32'(res_erro), 0);
        chk("midrst.ula_a", 32'(ula_a), 0);
        @(negedge clk);
        chk("midrst.op_ready", 32'(op_ready), 1);
        seq_val = 8'h0C; seq_done = 1'b1;
        @(negedge clk);
        seq_done = 1'b0;
        chk("late_done.res_valid", 32'(res_valid), 0);
        chk("late_done.ocupado", 32'(ocupado), 0);
        @(negedge clk);
        chk("late_done.res_valid2", 32'(res_valid), 0);
        run_op(tv[11], "post_rst_add");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
